kernel_window_gen: RTL and testbench

//  Parametrised KSIZE x KSIZE sliding-window generator for the median-filter datapath; sits between HDMI RX and the filter core.

---
 rtl/kernel_window_gen_pkg.sv | 19 +
 rtl/kernel_window_gen_line_ram.sv | 27 ++
 rtl/kernel_window_gen.sv | 207 ++++++++++++++++++++
 tb/tb_kernel_window_gen.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_window_gen_pkg.sv
// Shared constants and helpers for the KSIZE x KSIZE sliding-window generator.
package kernel_window_gen_pkg;

    localparam int PIX_W     = 24;
    localparam int CH_W      = 8;
    localparam int RED_OFS   = 16;
    localparam int GREEN_OFS = 8;
    localparam int BLUE_OFS  = 0;

    function automatic bit ksize_ok(input int k);
        return (k >= 3) && (k <= 9) && ((k % 2) == 1);
    endfunction

    // Flat element index of window position (r,c); r=0 oldest line, c=0 oldest column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/kernel_window_gen_line_ram.sv
// Simple dual-port line buffer with registered read; contents are never reset.
module kernel_window_gen_line_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/kernel_window_gen.sv
// Sliding-window generator: KSIZE-1 cascaded line buffers feed per-row column shifters.
//   state      | meaning
//   WAIT_VS    | idle until rx_vs falls
//   FIRST_LINE | measuring frame_width on line 0
//   FILL       | loading line buffers, no windows yet
//   STREAM     | full windows available on interior pixels
module kernel_window_gen
    import kernel_window_gen_pkg::*;
#(
    parameter int KSIZE     = 5,
    parameter int DATA_W    = PIX_W,
    parameter int MAX_WIDTH = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_dv,
    input  logic                          rx_hs,
    input  logic                          rx_vs,
    output logic [KSIZE*KSIZE*DATA_W-1:0] win_data,
    output logic                          win_valid,
    output logic [ADDR_W-1:0]             win_col,
    output logic [11:0]                   win_row,
    output logic [ADDR_W:0]               frame_width,
    output logic                          line_err
);

    localparam logic [1:0] ST_WAIT_VS    = 2'd0;
    localparam logic [1:0] ST_FIRST_LINE = 2'd1;
    localparam logic [1:0] ST_FILL       = 2'd2;
    localparam logic [1:0] ST_STREAM     = 2'd3;

    localparam int HALF = (KSIZE - 1) / 2;
    localparam logic [ADDR_W:0]   COL_MIN  = (ADDR_W+1)'(KSIZE - 1);
    localparam logic [ADDR_W:0]   COL_MAX  = (ADDR_W+1)'(MAX_WIDTH);
    localparam logic [ADDR_W:0]   COL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] COL_HALF = ADDR_W'(HALF);
    localparam logic [11:0]       ROW_MIN  = 12'(KSIZE - 1);
    localparam logic [11:0]       ROW_HALF = 12'(HALF);

    if (!ksize_ok(KSIZE)) begin : g_ksize_check
        $error("kernel_window_gen: KSIZE must be odd and within 3..9");
    end

    logic [1:0]        state;
    logic              vs_d;
    logic [ADDR_W:0]   col;
    logic [11:0]       row;

    logic              active;
    logic              accept;
    logic              beat_drop;
    logic              line_end;
    logic              in_window;
    logic [ADDR_W:0]   line_len;

    assign active    = (state != ST_WAIT_VS) && !rx_vs;
    assign accept    = active && rx_dv && (col != COL_MAX);
    assign beat_drop = active && rx_dv && (col == COL_MAX);
    assign line_end  = active && rx_hs;
    assign in_window = accept && (row >= ROW_MIN) && (col >= COL_MIN);
    // A beat arriving with rx_hs still belongs to the line it ends.
    assign line_len  = accept ? (col + COL_ONE) : col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WAIT_VS;
            vs_d        <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_width <= '0;
            line_err    <= 1'b0;
        end else begin
            vs_d <= rx_vs;
            if (rx_vs) begin
                state    <= ST_WAIT_VS;
                col      <= '0;
                row      <= '0;
                line_err <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_VS:    if (vs_d) state <= ST_FIRST_LINE;
                    ST_FIRST_LINE: if (line_end) begin
                        state       <= ST_FILL;
                        frame_width <= line_len;
                    end
                    ST_FILL:       if (row == ROW_MIN) state <= ST_STREAM;
                    default:       ;
                endcase
                if (line_end) begin
                    col <= '0;
                    row <= row + 12'd1;
                    if (state != ST_FIRST_LINE && line_len != frame_width) begin
                        line_err <= 1'b1;
                    end
                end else if (accept) begin
                    col <= col + COL_ONE;
                end
                if (beat_drop) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

    logic [DATA_W-1:0] ram_rd [KSIZE-1];
    logic [DATA_W-1:0] ram_wr [KSIZE-1];
    logic [DATA_W-1:0] col_in [KSIZE];
    logic [DATA_W-1:0] shreg  [KSIZE][KSIZE];

    logic [DATA_W-1:0] pix_d;
    logic [ADDR_W-1:0] col_d;
    logic              beat_d;
    logic              win_d;
    logic [ADDR_W-1:0] wcol_d;
    logic [11:0]       wrow_d;
    logic              win_q;
    logic [ADDR_W-1:0] wcol_q;
    logic [11:0]       wrow_q;
    logic [KSIZE*KSIZE*DATA_W-1:0] win_flat;

    // Each buffer is read at the beat's edge and rewritten one edge later at the same column.
    for (genvar j = 0; j < KSIZE - 1; j++) begin : g_ram
        if (j == 0) begin : g_head
            assign ram_wr[j] = pix_d;
        end else begin : g_chain
            assign ram_wr[j] = ram_rd[j-1];
        end
        kernel_window_gen_line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_WIDTH),
            .ADDR_W (ADDR_W)
        ) u_line_ram (
            .clk   (clk),
            .we    (beat_d),
            .waddr (col_d),
            .wdata (ram_wr[j]),
            .re    (accept),
            .raddr (col[ADDR_W-1:0]),
            .rdata (ram_rd[j])
        );
    end

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        if (r == KSIZE - 1) begin : g_live
            assign col_in[r] = pix_d;
        end else begin : g_buf
            assign col_in[r] = ram_rd[KSIZE-2-r];
        end
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            assign win_flat[win_idx(r, c, KSIZE)*DATA_W +: DATA_W] = shreg[r][c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_d     <= '0;
            col_d     <= '0;
            beat_d    <= 1'b0;
            win_d     <= 1'b0;
            wcol_d    <= '0;
            wrow_d    <= '0;
            win_q     <= 1'b0;
            wcol_q    <= '0;
            wrow_q    <= '0;
            win_data  <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    shreg[r][c] <= '0;
                end
            end
        end else begin
            beat_d <= accept;
            win_d  <= in_window;
            if (accept) begin
                pix_d  <= rx_data;
                col_d  <= col[ADDR_W-1:0];
                wcol_d <= col[ADDR_W-1:0] - COL_HALF;
                wrow_d <= row - ROW_HALF;
            end

            win_q <= win_d && !rx_vs;
            if (beat_d) begin
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        shreg[r][c] <= shreg[r][c+1];
                    end
                    shreg[r][KSIZE-1] <= col_in[r];
                end
                wcol_q <= wcol_d;
                wrow_q <= wrow_d;
            end

            win_valid <= win_q && !rx_vs;
            if (win_q && !rx_vs) begin
                win_data <= win_flat;
                win_col  <= wcol_q;
                win_row  <= wrow_q;
            end
        end
    end

endmodule

// File: tb/tb_kernel_window_gen.sv
// Bench for kernel_window_gen: drives video frames and compares windows with a frame-array model.
module tb_kernel_window_gen;
    import kernel_window_gen_pkg::*;

    localparam int K    = 5;
    localparam int DW   = 24;
    localparam int MW   = 16;
    localparam int AW   = 4;
    localparam int HALF = (K - 1) / 2;

    typedef struct packed {
        logic [K*K*DW-1:0] data;
        logic [AW-1:0]     col;
        logic [11:0]       row;
    } win_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW-1:0]     rx_data = '0;
    logic              rx_dv = 1'b0;
    logic              rx_hs = 1'b0;
    logic              rx_vs = 1'b0;
    logic [K*K*DW-1:0] win_data;
    logic              win_valid;
    logic [AW-1:0]     win_col;
    logic [11:0]       win_row;
    logic [AW:0]       frame_width;
    logic              line_err;

    kernel_window_gen #(
        .KSIZE     (K),
        .DATA_W    (DW),
        .MAX_WIDTH (MW),
        .ADDR_W    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_dv       (rx_dv),
        .rx_hs       (rx_hs),
        .rx_vs       (rx_vs),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .win_col     (win_col),
        .win_row     (win_row),
        .frame_width (frame_width),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_row = 0;
    int hold_viol = 0;
    bit hold_on = 1'b0;
    logic [K*K*DW-1:0] prev_data = '0;
    logic [DW-1:0] frame_pix [0:15][0:31];
    win_t exp_q[$];
    win_t obs_q[$];
    win_t basic_q[$];

    always @(negedge clk) begin
        win_t w;
        if (win_valid === 1'b1) begin
            w.data = win_data;
            w.col  = win_col;
            w.row  = win_row;
            obs_q.push_back(w);
        end
        if (hold_on && win_valid !== 1'b1 && win_data !== prev_data) hold_viol++;
        prev_data = win_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] make_pix(input int r, input int c, input int mode);
        logic [DW-1:0] p;
        if (mode == 0) p = {12'(r), 12'(c)};
        else p = (DW'($urandom_range(0, 255)) << RED_OFS) |
                 (DW'($urandom_range(0, 255)) << GREEN_OFS) |
                 (DW'($urandom_range(0, (1 << CH_W) - 1)) << BLUE_OFS);
        return p;
    endfunction

    // Reference: a pixel beyond MW is dropped; interior pixels yield the KxK block ending at them.
    task automatic model_beat(input int r, input int c, input logic [DW-1:0] p);
        win_t w;
        if (c < MW) begin
            frame_pix[r][c] = p;
            if (r >= K - 1 && c >= K - 1) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        w.data[(i*K+j)*DW +: DW] = frame_pix[r-(K-1)+i][c-(K-1)+j];
                w.col = AW'(c - HALF);
                w.row = 12'(r - HALF);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic begin_lines();
        cur_row = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic start_frame();
        rx_dv = 1'b0;
        rx_hs = 1'b0;
        rx_vs = 1'b1;
        repeat (3) tick();
        rx_vs = 1'b0;
        repeat (2) tick();
        begin_lines();
    endtask

    // end_mode: 0 hs after line, 1 hs with last beat, 2 no line end
    task automatic drive_line(input int len, input int gap_mode, input int pix_mode, input int end_mode);
        logic [DW-1:0] p;
        for (int c = 0; c < len; c++) begin
            if ((gap_mode == 1 && (c % 3) == 2) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                rx_dv = 1'b0;
                rx_data = DW'($urandom);
                repeat ((gap_mode == 2) ? $urandom_range(1, 2) : 1) tick();
            end
            p = make_pix(cur_row, c, pix_mode);
            rx_dv = 1'b1;
            rx_data = p;
            if (end_mode == 1 && c == len - 1) rx_hs = 1'b1;
            model_beat(cur_row, c, p);
            tick();
            rx_hs = 1'b0;
        end
        rx_dv = 1'b0;
        if (end_mode == 0) begin
            rx_hs = 1'b1;
            tick();
            rx_hs = 1'b0;
        end
        if (end_mode != 2) begin
            repeat (3) tick();
            cur_row++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_col !== '0 || win_row !== '0) begin
            n_fail++;
            $display("FAIL reset_win: valid=%b col=%0d row=%0d data_nonzero=%b, required all 0",
                     win_valid, win_col, win_row, |win_data);
        end
        n_tests++;
        if (frame_width !== '0 || line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: frame_width=%0d line_err=%b, required 0/0", frame_width, line_err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        start_frame();
        for (int r = 0; r < 4; r++) drive_line(8, 0, 1, 0);
        drive_line(6, 0, 1, 2);
        repeat (3) tick();
        n_tests++;
        if (frame_width !== 5'd8 || obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL midrst_pre: frame_width=%0d windows=%0d, required 8/2", frame_width, obs_q.size());
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_col !== '0 || win_row !== '0 ||
            frame_width !== '0 || line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b col=%0d row=%0d fw=%0d err=%b, required all 0",
                     win_valid, win_col, win_row, frame_width, line_err);
        end
        tick();
        rst = 1'b1;
        tick();
        begin_lines();
        for (int r = 0; r < 5; r++) drive_line(8, 0, 1, 0);
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_novs: got %0d windows before rx_vs, required 0", obs_q.size());
        end
        start_frame();
        for (int r = 0; r < 5; r++) drive_line(8, 0, 1, 0);
        n_tests++;
        if (obs_q.size() != 4 || exp_q.size() != 4 || obs_q != exp_q) begin
            n_fail++;
            $display("FAIL midrst_refill: got %0d windows (match=%b), required 4 matching",
                     obs_q.size(), obs_q == exp_q);
        end
    endtask

    task automatic test_basic();
        start_frame();
        for (int r = 0; r < 6; r++) drive_line(8, 0, 0, 0);
        n_tests++;
        if (frame_width !== 5'd8) begin
            n_fail++;
            $display("FAIL basic_width: got %0d, required 8", frame_width);
        end
        n_tests++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL basic_count: got %0d windows, required 8", obs_q.size());
        end
        n_tests++;
        if (obs_q.size() == 0 || obs_q[0].col !== 4'd2 || obs_q[0].row !== 12'd2) begin
            n_fail++;
            $display("FAIL basic_first_centre: got (%0d,%0d), required (2,2)",
                     obs_q.size() ? obs_q[0].row : 0, obs_q.size() ? obs_q[0].col : 0);
        end
        n_tests++;
        if (obs_q.size() == 0 || obs_q[0].data[0 +: DW] !== 24'h000000 ||
            obs_q[0].data[(K*K-1)*DW +: DW] !== 24'h004004) begin
            n_fail++;
            $display("FAIL basic_corners: got %h/%h, required 000000/004004",
                     obs_q.size() ? obs_q[0].data[0 +: DW] : 24'h0,
                     obs_q.size() ? obs_q[0].data[(K*K-1)*DW +: DW] : 24'h0);
        end
        n_tests++;
        if (obs_q != exp_q) begin
            n_fail++;
            $display("FAIL basic_windows: window sequence differs from model (%0d vs %0d)",
                     obs_q.size(), exp_q.size());
        end
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got %b, required 0", line_err);
        end
        basic_q = obs_q;
    endtask

    task automatic test_gaps();
        start_frame();
        hold_viol = 0;
        hold_on = 1'b1;
        for (int r = 0; r < 6; r++) drive_line(8, 1, 0, 0);
        hold_on = 1'b0;
        n_tests++;
        if (obs_q.size() != 8 || obs_q != basic_q) begin
            n_fail++;
            $display("FAIL gaps_sequence: got %0d windows (same=%b), required 8 identical to gapless",
                     obs_q.size(), obs_q == basic_q);
        end
        n_tests++;
        if (hold_viol != 0) begin
            n_fail++;
            $display("FAIL gaps_hold: win_data changed %0d times while idle, required 0", hold_viol);
        end
    endtask

    task automatic test_vs_abort();
        int bad;
        start_frame();
        for (int r = 0; r < 5; r++) drive_line(8, 0, 1, 0);
        drive_line(3, 0, 1, 2);
        rx_vs = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            rx_dv = 1'b1;
            rx_data = DW'($urandom);
            tick();
            if (win_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || obs_q.size() != 4 || obs_q != exp_q) begin
            n_fail++;
            $display("FAIL vs_abort: valid during vs=%0d windows=%0d, required 0 and 4 matching",
                     bad, obs_q.size());
        end
        rx_dv = 1'b0;
        tick();
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL vs_abort_err: got %b, required 0", line_err);
        end
        rx_vs = 1'b0;
        repeat (2) tick();
        begin_lines();
        for (int r = 0; r < 6; r++) drive_line(8, 0, 1, 0);
        n_tests++;
        if (obs_q.size() != 8 || obs_q != exp_q || line_err !== 1'b0 || frame_width !== 5'd8) begin
            n_fail++;
            $display("FAIL vs_restart: windows=%0d err=%b fw=%0d, required 8 matching/0/8",
                     obs_q.size(), line_err, frame_width);
        end
    endtask

    task automatic test_width_err();
        start_frame();
        for (int r = 0; r < 3; r++) drive_line(8, 0, 1, 0);
        drive_line(7, 0, 1, 2);
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL werr_before_hs: got %b, required 0", line_err);
        end
        rx_hs = 1'b1;
        tick();
        rx_hs = 1'b0;
        tick();
        cur_row++;
        n_tests++;
        if (line_err !== 1'b1) begin
            n_fail++;
            $display("FAIL werr_after_hs: got %b, required 1", line_err);
        end
        for (int r = 0; r < 2; r++) drive_line(8, 0, 1, 0);
        n_tests++;
        if (line_err !== 1'b1 || frame_width !== 5'd8) begin
            n_fail++;
            $display("FAIL werr_sticky: err=%b fw=%0d, required 1/8", line_err, frame_width);
        end
        start_frame();
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL werr_cleared: got %b, required 0", line_err);
        end
    endtask

    task automatic test_overflow();
        int far;
        start_frame();
        for (int r = 0; r < 4; r++) drive_line(16, 0, 1, 0);
        n_tests++;
        if (line_err !== 1'b0 || frame_width !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_full_width: err=%b fw=%0d, required 0/16", line_err, frame_width);
        end
        drive_line(17, 0, 1, 0);
        drive_line(16, 0, 1, 0);
        far = 0;
        foreach (obs_q[i]) if (obs_q[i].col > 4'd13) far++;
        n_tests++;
        if (obs_q.size() != 24 || far != 0 || obs_q != exp_q) begin
            n_fail++;
            $display("FAIL ovf_windows: windows=%0d beyond_col13=%0d, required 24 matching/0",
                     obs_q.size(), far);
        end
        n_tests++;
        if (line_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_err: got %b, required 1", line_err);
        end
    endtask

    task automatic test_random();
        int w;
        int rows;
        for (int f = 0; f < 3; f++) begin
            w = $urandom_range(6, 14);
            rows = $urandom_range(6, 8);
            start_frame();
            for (int r = 0; r < rows; r++) drive_line(w, 2, 1, $urandom_range(0, 1));
            n_tests++;
            if (obs_q.size() != (rows - K + 1) * (w - K + 1) || obs_q != exp_q) begin
                n_fail++;
                $display("FAIL random_frame%0d: windows=%0d, required %0d matching model",
                         f, obs_q.size(), (rows - K + 1) * (w - K + 1));
            end
            n_tests++;
            if (frame_width !== 5'(w) || line_err !== 1'b0) begin
                n_fail++;
                $display("FAIL random_status%0d: fw=%0d err=%b, required %0d/0", f, frame_width, line_err, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_basic();
        test_gaps();
        test_vs_abort();
        test_width_err();
        test_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
